// File: rtl/pipe_issue_ctrl_if.sv
// rtl/pipe_issue_ctrl_if.sv - ID-stage decode inputs and pipeline enable outputs of the issue controller
interface pipe_issue_ctrl_if;
    logic       if_id_valid_inst;
    logic [4:0] id_ra_idx;
    logic [4:0] id_rb_idx;
    logic       id_uses_ra;
    logic       id_uses_rb;
    logic       id_reg_wr;
    logic [4:0] id_dest_reg_idx;
    logic       id_is_mul;
    logic       id_illegal;
    logic       ex_take_branch;

    logic       pipe_en;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       issue;
    logic       should_stall;
    logic       halted;

    modport master (
        output if_id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_dest_reg_idx, id_is_mul, id_illegal, ex_take_branch,
        input  pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble, issue,
               should_stall, halted
    );

    modport slave (
        input  if_id_valid_inst, id_ra_idx, id_rb_idx, id_uses_ra, id_uses_rb,
               id_reg_wr, id_dest_reg_idx, id_is_mul, id_illegal, ex_take_branch,
        output pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble, issue,
               should_stall, halted
    );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - writeback scoreboard, MUL freeze, branch flush and halt control beside ID
module pipe_issue_ctrl #(
    parameter int WB_LAT     = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_issue_ctrl_if.slave  bus
);
    localparam int PW = $clog2(WB_LAT + 1);
    localparam int BW = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_BUSY = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic [PW-1:0] pend_q [32];

    logic pipe_en;
    logic flush;
    logic run;
    logic hz_ra;
    logic hz_rb;
    logic hz;
    logic stall;
    logic do_issue;
    logic load_rd;

    // Register 0 is hardwired, so its index never produces a hazard.
    assign hz_ra = bus.id_uses_ra & (bus.id_ra_idx != 5'd0) & (pend_q[bus.id_ra_idx] != '0);
    assign hz_rb = bus.id_uses_rb & (bus.id_rb_idx != 5'd0) & (pend_q[bus.id_rb_idx] != '0);
    assign hz    = hz_ra | hz_rb;

    assign pipe_en  = (state_q != MUL_BUSY);
    assign flush    = pipe_en & bus.ex_take_branch;
    assign run      = (state_q == RUN);
    assign stall    = pipe_en & ~flush & run & bus.if_id_valid_inst & hz;
    assign do_issue = pipe_en & ~flush & run & bus.if_id_valid_inst & ~hz;
    assign load_rd  = do_issue & bus.id_reg_wr & (bus.id_dest_reg_idx != 5'd0);

    assign bus.pipe_en      = pipe_en;
    assign bus.if_id_flush  = flush;
    assign bus.should_stall = stall;
    assign bus.issue        = do_issue;
    assign bus.id_ex_bubble = ~do_issue;
    assign bus.pc_en        = pipe_en & ~stall & (state_q != HALTED);
    assign bus.if_id_en     = pipe_en & ~stall & (state_q != HALTED);
    assign bus.halted       = (state_q == HALTED);

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            RUN: begin
                if (do_issue && bus.id_illegal) begin
                    state_d = HALTED;
                end else if (do_issue && bus.id_is_mul) begin
                    state_d    = MUL_BUSY;
                    busy_cnt_d = BW'(MUL_CYCLES - 1);
                end
            end
            MUL_BUSY: begin
                busy_cnt_d = busy_cnt_q - BW'(1);
                if (busy_cnt_q == BW'(1)) begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // A fresh issue to rd reloads the full latency even if an older write is still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                pend_q[i] <= '0;
            end
        end else if (pipe_en) begin
            pend_q[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (load_rd && (bus.id_dest_reg_idx == 5'(i))) begin
                    pend_q[i] <= PW'(WB_LAT);
                end else if (pend_q[i] != '0) begin
                    pend_q[i] <= pend_q[i] - PW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - directed scoreboard bench for pipe_issue_ctrl
module tb_pipe_issue_ctrl;
    logic clk;
    logic rst;

    pipe_issue_ctrl_if bus ();

    pipe_issue_ctrl #(.WB_LAT(3), .MUL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble, issue, should_stall, halted}
    localparam logic [7:0] E_IDLE   = 8'b1110_1000;
    localparam logic [7:0] E_ISSUE  = 8'b1110_0100;
    localparam logic [7:0] E_STALL  = 8'b1000_1010;
    localparam logic [7:0] E_FREEZE = 8'b0000_1000;
    localparam logic [7:0] E_FLUSH  = 8'b1111_1000;
    localparam logic [7:0] E_HALT   = 8'b1000_1001;
    localparam logic [7:0] E_HALTBR = 8'b1001_1001;

    logic [7:0] exp_q [$];
    string      tag_q [$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [7:0] observed();
        return {bus.pipe_en, bus.pc_en, bus.if_id_en, bus.if_id_flush,
                bus.id_ex_bubble, bus.issue, bus.should_stall, bus.halted};
    endfunction

    task automatic drive(input logic valid, input logic [4:0] ra, input logic ura,
                         input logic [4:0] rb, input logic urb, input logic wr,
                         input logic [4:0] rd, input logic mul, input logic ill,
                         input logic br);
        bus.if_id_valid_inst = valid;
        bus.id_ra_idx        = ra;
        bus.id_uses_ra       = ura;
        bus.id_rb_idx        = rb;
        bus.id_uses_rb       = urb;
        bus.id_reg_wr        = wr;
        bus.id_dest_reg_idx  = rd;
        bus.id_is_mul        = mul;
        bus.id_illegal       = ill;
        bus.ex_take_branch   = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expectation is queued when stimulus is applied and retired at the falling edge.
    task automatic cyc(input logic [7:0] exp, input string tag);
        logic [7:0] e;
        string      t;
        logic [7:0] o;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            cyc(E_IDLE, "drain");
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        cyc(E_IDLE, "reset_state");
        rst = 1'b1;

        // lw x5 then add x6,x5,x0
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd5, 0, 0, 0); cyc(E_ISSUE, "lw_issue");
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 0); cyc(E_STALL, "raw_stall");
        end
        drive(1, 5'd5, 1, 5'd0, 1, 1, 5'd6, 0, 0, 0); cyc(E_ISSUE, "raw_issue");
        // write to x0 then read x0
        drive(1, 5'd2, 1, 5'd0, 0, 1, 5'd0, 0, 0, 0); cyc(E_ISSUE, "x0_wr_issue");
        drive(1, 5'd0, 1, 5'd0, 1, 1, 5'd8, 0, 0, 0); cyc(E_ISSUE, "x0_rd_nostall");
        idle_n(3);

        // addi x7 then sw reading x7 via rb
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 0, 0, 0); cyc(E_ISSUE, "addi_issue");
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd1, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0); cyc(E_STALL, "rb_stall");
        end
        drive(1, 5'd1, 1, 5'd7, 1, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "rb_issue");
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 0, 0, 0); cyc(E_ISSUE, "addi2_issue");
        drive(1, 5'd1, 1, 5'd7, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "rb_unused_nostall");
        idle_n(3);

        // mul x3 then dependent add; branch during freeze is ignored
        drive(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 1, 0, 0); cyc(E_ISSUE, "mul_issue");
        drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_FREEZE, "mul_freeze1");
        drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1); cyc(E_FREEZE, "mul_freeze_br");
        drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_FREEZE, "mul_freeze3");
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_STALL, "mul_dep_stall");
        end
        drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "mul_dep_issue");
        idle_n(1);

        // flush beats hazard; flushed mul writing x10 leaves no trace
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd9, 0, 0, 0); cyc(E_ISSUE, "prod_x9");
        drive(1, 5'd9, 1, 5'd0, 0, 1, 5'd10, 1, 0, 1); cyc(E_FLUSH, "flush_over_hazard");
        for (int k = 0; k < 2; k++) begin
            drive(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_STALL, "post_flush_stall");
        end
        drive(1, 5'd9, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "post_flush_issue");
        drive(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "flushed_rd_clear");
        idle_n(3);

        // illegal issue halts; branch still flushes; reset recovers
        drive(1, 5'd1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0); cyc(E_ISSUE, "ebreak_issue");
        drive(1, 5'd1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_HALT, "halted");
        drive(1, 5'd1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1); cyc(E_HALTBR, "halted_branch");
        idle(); cyc(E_HALT, "halted_hold");
        rst = 1'b0;
        idle(); cyc(E_IDLE, "halt_reset");
        rst = 1'b1;
        drive(1, 5'd1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "after_halt_issue");

        // reset mid-hazard clears the scoreboard
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd12, 0, 0, 0); cyc(E_ISSUE, "prod_x12");
        drive(1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_STALL, "x12_stall");
        rst = 1'b0;
        idle(); cyc(E_IDLE, "reset_mid_hazard");
        rst = 1'b1;
        drive(1, 5'd12, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "x12_after_reset");

        // reset mid-MUL aborts the freeze
        drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 1, 0, 0); cyc(E_ISSUE, "mul2_issue");
        idle(); cyc(E_FREEZE, "mul2_freeze");
        rst = 1'b0;
        idle(); cyc(E_IDLE, "reset_mid_mul");
        rst = 1'b1;
        idle(); cyc(E_IDLE, "after_mul_reset");
        drive(1, 5'd4, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); cyc(E_ISSUE, "x4_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_issue_ctrl.md
# pipe_issue_ctrl

Issue controller for the five-stage pipeline, placed beside the ID stage. It keeps a per-register scoreboard of in-flight writebacks, holds dependent instructions in ID, and inserts bubbles into ID/EX. It freezes the whole pipeline while a multi-cycle MUL/MULHU occupies EX, flushes on a taken branch, and halts fetch when an illegal or ebreak instruction issues. It drives every pipeline-register and PC enable.

## Interface
- WB_LAT, 3: cycles from issue until the issued instruction's result is readable from the regfile.
- MUL_CYCLES, 4: EX occupancy of MUL/MULHU in cycles; ≥2.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0); clk is the only clock.
- if_id_valid_inst  input  1  IF/ID holds a real instruction.
- id_ra_idx, id_rb_idx  input  5  source register indices.
- id_uses_ra, id_uses_rb  input  1  instruction actually reads that source.
- id_reg_wr  input  1  instruction writes rd.
- id_dest_reg_idx  input  5  rd (0 when no writeback).
- id_is_mul  input  1  decoded ALU_MUL or ALU_MULHU.
- id_illegal  input  1  decoder illegal flag; ebreak is treated as illegal.
- ex_take_branch  input  1  branch/jump in EX is taken.
- pipe_en  output  1  global enable for ID/EX, EX/MEM and MEM/WB registers.
- pc_en  output  1  PC register load enable.
- if_id_en  output  1  IF/ID load enable.
- if_id_flush  output  1  load a NOP into IF/ID.
- id_ex_bubble  output  1  load a NOP into ID/EX instead of the decoded instruction.
- issue  output  1  the instruction in ID enters EX this cycle.
- should_stall  output  1  data hazard is holding ID.
- halted  output  1  controller is in HALTED.

## Operation
- State: FSM in {RUN, MUL_BUSY, HALTED}; busy_cnt (width clog2(MUL_CYCLES)); pend[1..31], each a clog2(WB_LAT+1)-bit down-counter. pend[0] is constantly 0.
- Hazard: hz = (id_uses_ra & pend[id_ra_idx]≠0) | (id_uses_rb & pend[id_rb_idx]≠0). Index 0 never causes a hazard.
- Combinational outputs:
  - pipe_en = (state≠MUL_BUSY).
  - flush = pipe_en & ex_take_branch.
  - should_stall = pipe_en & ~flush & state==RUN & if_id_valid_inst & hz.
  - issue = pipe_en & ~flush & state==RUN & if_id_valid_inst & ~hz.
  - id_ex_bubble = ~issue.
  - if_id_flush = flush.
  - pc_en = if_id_en = pipe_en & ~should_stall & state≠HALTED.
- Priority: freeze (MUL_BUSY) > flush > hazard. A flushed ID instruction is discarded and does not update the scoreboard, the FSM or halted.
- Scoreboard update, only on cycles with pipe_en=1:
  - Every nonzero pend decrements by 1.
  - On issue & id_reg_wr & id_dest_reg_idx≠0, pend[rd] loads WB_LAT. This overrides the decrement; re-issue to a still-pending rd reloads it.
  - With pipe_en=0, all pend hold.
- FSM transitions:
  - RUN → MUL_BUSY on issue & id_is_mul & ~id_illegal; busy_cnt ← MUL_CYCLES−1.
  - RUN → HALTED on issue & id_illegal. Issue is still reported so the instruction retires for CPI counting.
  - MUL_BUSY: busy_cnt decrements each cycle; → RUN when busy_cnt==1. This gives exactly MUL_CYCLES−1 frozen cycles.
  - HALTED: absorbing until reset. issue=0, pc_en=if_id_en=0, pipe_en=1 so older instructions drain. Branches in EX still assert if_id_flush.
- Reset (rst=0, asynchronous): state=RUN, busy_cnt=0, all pend=0, halted=0. With if_id_valid_inst=0 the outputs are pipe_en=1, pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=1, issue=0, should_stall=0. Reset asserted mid-MUL or mid-hazard aborts immediately; no pending state survives.

## Timing
- All outputs are combinational from state and current-cycle inputs. Every state update occurs on the rising clk edge.
- Producer issued in cycle t: a dependent consumer stalls in t+1..t+WB_LAT and issues in t+WB_LAT+1 (t+4 at default). Each frozen cycle in between adds 1.
- MUL issued in t: pipe_en=0 in t+1..t+MUL_CYCLES−1 and 1 again in t+MUL_CYCLES.
- ex_take_branch is ignored while pipe_en=0; EX is frozen and re-presents it.
- Flush is single-cycle: the instruction in ID is bubbled and IF/ID receives a NOP at the next edge.

## Test plan
- Reset: drive rst=0 mid-stream → all outputs take the reset values above; pend all 0 on release.
- RAW on load: issue lw x5 at t, then add x6,x5,x0 → should_stall=1 and id_ex_bubble=1 in t+1..t+3; issue=1 at t+4. Repeat with x0 as rd → no stall.
- Independent/rs2-only: addi x7 followed by sw that reads x7 via rb → stall 3 cycles. Same sequence with id_uses_rb=0 → no stall.
- MUL freeze: mul x3 at t (MUL_CYCLES=4) → pipe_en=0 in t+1..t+3; a dependent add issues at t+7; pend[x3] holds during the freeze.
- Flush vs hazard: ex_take_branch=1 while ID has a hazard → if_id_flush=1, pc_en=1, should_stall=0, issue=0, scoreboard unchanged.
- Halt: ebreak/illegal issues at t → issue=1 at t, halted=1 from t+1, pc_en=0 thereafter; rst=0 then 1 → RUN, pc_en=1.
